if_stage: RTL

Instruction-fetch stage of the RV32IM five-stage pipeline, directly upstream of the decode stage. Holds the fetch PC, issues in-order requests to the instruction-memory port, buffers returned words in a 2-entry queue and presents one instruction per cycle in the IF/ID output register. It honours decode-side stalls and squashes all in-flight and buffered fetches when the execute stage redirects the PC (taken branch, JAL, JALR).

---
 rtl/if_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: RV32IM instruction-fetch stage with in-order request tracking,
// a 2-entry instruction queue and a registered IF/ID output.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     fetch request handshake, imem_addr = fetch PC
//   imem_rsp_valid/data      in-order response words (no back-pressure)
//   redirect_valid/pc        execute-stage PC redirect (squashes fetches)
//   stall                    hold the IF/ID register
//   if_valid/pc/instr        registered instruction presented to decode
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    logic [31:0] r_fetch_pc;

    // PCs of accepted requests; occupancy equals r_inflight
    logic [31:0] r_rq_pc [2];
    logic        r_rq_rd;
    logic [1:0]  r_inflight;
    logic [1:0]  r_discard;

    // instruction queue of {pc, instr}
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic        r_q_rd;
    logic [1:0]  r_q_cnt;

    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic [2:0]  w_credit;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_rq_wr;
    logic [31:0] w_rsp_pc;
    logic        w_rsp_drop;
    logic        w_rsp_live;
    logic [1:0]  w_inflight_nxt;
    logic        w_q_pop;
    logic        w_q_push;
    logic        w_q_wr;
    logic [31:0] w_redirect_pc;
    logic        w_unused;

    // outstanding requests plus buffered words never exceed 2,
    // so every response always has a queue slot
    assign w_credit    = {1'b0, r_inflight} + {1'b0, r_q_cnt};
    assign w_req_valid = !rst && !redirect_valid && (w_credit < 3'd2);
    assign w_req_fire  = w_req_valid && imem_req_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_fetch_pc;

    // write slot is read pointer plus occupancy (occupancy <= 1 on push)
    assign w_rq_wr  = r_rq_rd ^ r_inflight[0];
    assign w_rsp_pc = r_rq_pc[r_rq_rd];

    assign w_rsp_drop = imem_rsp_valid && (r_discard != 2'd0);
    // a response in the redirect cycle belongs to the old path
    assign w_rsp_live = imem_rsp_valid && (r_discard == 2'd0)
                        && !redirect_valid;

    assign w_inflight_nxt = r_inflight + {1'b0, w_req_fire}
                            - {1'b0, imem_rsp_valid};

    assign w_q_pop  = !redirect_valid && !stall && (r_q_cnt != 2'd0);
    assign w_q_push = w_rsp_live && (stall || (r_q_cnt != 2'd0));
    assign w_q_wr   = r_q_rd ^ r_q_cnt[0];

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 2'd0;
            r_discard  <= 2'd0;
            r_rq_rd    <= 1'b0;
            r_q_cnt    <= 2'd0;
            r_q_rd     <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (imem_rsp_valid) begin
                r_rq_rd <= ~r_rq_rd;
            end
            if (redirect_valid) begin
                // everything still outstanding after this cycle is stale
                r_fetch_pc <= w_redirect_pc;
                r_discard  <= w_inflight_nxt;
                r_q_cnt    <= 2'd0;
                r_q_rd     <= 1'b0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_discard <= r_discard - 2'd1;
                end
                r_q_cnt <= r_q_cnt + {1'b0, w_q_push}
                           - {1'b0, w_q_pop};
                if (w_q_pop) begin
                    r_q_rd <= ~r_q_rd;
                end
            end
        end
    end

    // payload storage needs no reset; occupancy qualifies it
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_rq_pc[w_rq_wr] <= r_fetch_pc;
        end
        if (w_q_push) begin
            r_q_pc[w_q_wr]    <= w_rsp_pc;
            r_q_instr[w_q_wr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (w_q_pop) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_q_pc[r_q_rd];
                r_if_instr <= r_q_instr[r_q_rd];
            end else if (w_rsp_live) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= w_rsp_pc;
                r_if_instr <= imem_rsp_data;
            end else begin
                r_if_valid <= 1'b0;
                r_if_pc    <= 32'd0;
                r_if_instr <= NOP_INSTR;
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

endmodule
